// File: rtl/udp_rx_pkg.sv
// rtl/udp_rx_pkg.sv - shared states and protocol constants for the RMII UDP receiver
package udp_rx_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREAMBLE,
    S_ETH_HDR,
    S_IP_HDR,
    S_UDP_HDR,
    S_PAYLOAD,
    S_PAD,
    S_DROP
  } rx_state_e;

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_VER_IHL     = 8'h45;
  localparam logic [7:0]  IP_PROTO_UDP   = 8'd17;
  localparam logic [31:0] CRC32_POLY     = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT     = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE  = 32'hDEBB20E3;
  localparam logic [7:0]  SFD_BYTE       = 8'hD5;

endpackage

// File: rtl/crc32_d8.sv
// rtl/crc32_d8.sv - combinational byte-wide reflected CRC-32 next-state function
module crc32_d8
  import udp_rx_pkg::*;
(
  input  logic [31:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  function automatic logic [31:0] next_crc(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'd0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
    end
    return c;
  endfunction

  assign crc_o = next_crc(crc_i, data_i);

endmodule

// File: rtl/udp_rx.sv
// rtl/udp_rx.sv - RMII receiver: preamble strip, Ethernet/IPv4/UDP header filter,
// payload byte stream and end-of-frame FCS status.
module udp_rx
  import udp_rx_pkg::*;
#(
  parameter logic [15:0] udp_my_port = 16'd11451,
  parameter logic [31:0] my_ip_adr   = {8'd192, 8'd168, 8'd15, 8'd14},
  parameter logic [47:0] mac_my_adr  = {8'he8, 8'h6a, 8'h64, 8'hfa, 8'hd1, 8'h7b}
) (
  input  logic        I_clk50m,
  input  logic        I_rst,
  input  logic [1:0]  I_rxd,
  input  logic        I_crs_dv,
  output logic [7:0]  O_data,
  output logic        O_dataValid,
  output logic        O_sof,
  output logic [15:0] O_dataLen,
  output logic [31:0] O_srcIp,
  output logic [15:0] O_srcPort,
  output logic        O_done,
  output logic        O_crcOk,
  output logic        O_busy
);

  rx_state_e   state_q;
  logic [7:0]  sr_q;
  logic [1:0]  dib_q;
  logic        low_q;
  logic [5:0]  hdr_cnt_q;
  logic [15:0] pay_cnt_q;
  logic [39:0] fld_q;
  logic [31:0] crc_q;
  logic [31:0] src_ip_q;
  logic [15:0] src_port_q;
  logic [15:0] len_q;
  logic [7:0]  data_q;
  logic        valid_q, sof_q, done_q, crc_ok_q, busy_q;
  logic [15:0] data_len_q, out_port_q;
  logic [31:0] out_ip_q;

  logic [7:0]  sr_d;
  logic [47:0] fld_d;
  logic [31:0] crc_d;
  logic        in_frame, byte_done, eof;

  assign sr_d      = {I_rxd, sr_q[7:2]};
  assign fld_d     = {fld_q, sr_d};
  assign in_frame  = (state_q != S_IDLE) && (state_q != S_PREAMBLE);
  assign byte_done = in_frame && I_crs_dv && (dib_q == 2'd3);
  // Two consecutive low samples are needed so a toggling CRS_DV does not end the frame.
  assign eof       = !I_crs_dv && low_q;

  crc32_d8 u_crc32_d8 (
    .crc_i  (crc_q),
    .data_i (sr_d),
    .crc_o  (crc_d)
  );

  always_ff @(posedge I_clk50m or posedge I_rst) begin
    if (I_rst) begin
      state_q    <= S_IDLE;
      sr_q       <= '0;
      dib_q      <= '0;
      low_q      <= 1'b0;
      hdr_cnt_q  <= '0;
      pay_cnt_q  <= '0;
      fld_q      <= '0;
      crc_q      <= CRC32_INIT;
      src_ip_q   <= '0;
      src_port_q <= '0;
      len_q      <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      sof_q      <= 1'b0;
      done_q     <= 1'b0;
      crc_ok_q   <= 1'b0;
      busy_q     <= 1'b0;
      data_len_q <= '0;
      out_ip_q   <= '0;
      out_port_q <= '0;
    end else begin
      valid_q <= 1'b0;
      sof_q   <= 1'b0;
      done_q  <= 1'b0;
      low_q   <= !I_crs_dv;
      if (I_crs_dv) begin
        sr_q  <= sr_d;
        dib_q <= dib_q + 2'd1;
      end
      if (byte_done) begin
        fld_q     <= fld_d[39:0];
        crc_q     <= crc_d;
        hdr_cnt_q <= hdr_cnt_q + 6'd1;
      end

      if (state_q != S_IDLE && eof) begin
        if (state_q == S_PAYLOAD || state_q == S_PAD) begin
          done_q   <= 1'b1;
          crc_ok_q <= (state_q == S_PAD) && (crc_q == CRC32_RESIDUE);
        end
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            pay_cnt_q <= '0;
            if (I_crs_dv && I_rxd == 2'b01) state_q <= S_PREAMBLE;
            else                            sr_q    <= '0;
          end
          S_PREAMBLE: begin
            if (I_crs_dv && sr_d == SFD_BYTE) begin
              state_q   <= S_ETH_HDR;
              dib_q     <= '0;
              hdr_cnt_q <= '0;
              crc_q     <= CRC32_INIT;
              busy_q    <= 1'b1;
            end
          end
          S_ETH_HDR: if (byte_done) begin
            if (hdr_cnt_q == 6'd5 && fld_d != mac_my_adr && fld_d != '1) state_q <= S_DROP;
            if (hdr_cnt_q == 6'd13) begin
              hdr_cnt_q <= '0;
              state_q   <= (fld_d[15:0] == ETHERTYPE_IPV4) ? S_IP_HDR : S_DROP;
            end
          end
          S_IP_HDR: if (byte_done) begin
            if (hdr_cnt_q == 6'd0 && fld_d[7:0] != IP_VER_IHL)   state_q <= S_DROP;
            if (hdr_cnt_q == 6'd9 && fld_d[7:0] != IP_PROTO_UDP) state_q <= S_DROP;
            if (hdr_cnt_q == 6'd15) src_ip_q <= fld_d[31:0];
            if (hdr_cnt_q == 6'd19) begin
              hdr_cnt_q <= '0;
              state_q   <= (fld_d[31:0] == my_ip_adr) ? S_UDP_HDR : S_DROP;
            end
          end
          S_UDP_HDR: if (byte_done) begin
            if (hdr_cnt_q == 6'd1) src_port_q <= fld_d[15:0];
            if (hdr_cnt_q == 6'd3 && fld_d[15:0] != udp_my_port) state_q <= S_DROP;
            if (hdr_cnt_q == 6'd5) begin
              if (fld_d[15:0] < 16'd8) state_q <= S_DROP;
              else                     len_q   <= fld_d[15:0] - 16'd8;
            end
            if (hdr_cnt_q == 6'd7) begin
              pay_cnt_q <= '0;
              state_q   <= (len_q == 16'd0) ? S_PAD : S_PAYLOAD;
            end
          end
          S_PAYLOAD: if (byte_done) begin
            data_q  <= sr_d;
            valid_q <= 1'b1;
            // Frame identity is published together with its first byte so it stays tied to O_sof.
            if (pay_cnt_q == 16'd0) begin
              sof_q      <= 1'b1;
              data_len_q <= len_q;
              out_ip_q   <= src_ip_q;
              out_port_q <= src_port_q;
            end
            pay_cnt_q <= pay_cnt_q + 16'd1;
            if (pay_cnt_q + 16'd1 == len_q) state_q <= S_PAD;
          end
          default: ;
        endcase
      end
    end
  end

  assign O_data      = data_q;
  assign O_dataValid = valid_q;
  assign O_sof       = sof_q;
  assign O_dataLen   = data_len_q;
  assign O_srcIp     = out_ip_q;
  assign O_srcPort   = out_port_q;
  assign O_done      = done_q;
  assign O_crcOk     = crc_ok_q;
  assign O_busy      = busy_q;

endmodule

// File: tb/tb_udp_rx.sv
// tb/tb_udp_rx.sv - randomized self-checking bench for udp_rx against a frame-level model
module tb_udp_rx;

  localparam bit [47:0] MY_MAC  = 48'he86a64fad17b;
  localparam bit [31:0] MY_IP   = {8'd192, 8'd168, 8'd15, 8'd14};
  localparam bit [15:0] MY_PORT = 16'd11451;

  typedef struct {
    bit [47:0] dmac;
    bit [15:0] etype;
    bit [7:0]  verihl;
    bit [7:0]  proto;
    bit [31:0] sip;
    bit [31:0] dip;
    bit [15:0] sport;
    bit [15:0] dport;
    bit [15:0] ulen;
    int        npay;
    int        flip;
    bit        rnd;
  } frame_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  rxd = 2'b00;
  logic        crs = 1'b0;
  logic [7:0]  O_data;
  logic        O_dataValid, O_sof, O_done, O_crcOk, O_busy;
  logic [15:0] O_dataLen, O_srcPort;
  logic [31:0] O_srcIp;

  udp_rx dut (
    .I_clk50m    (clk),
    .I_rst       (rst),
    .I_rxd       (rxd),
    .I_crs_dv    (crs),
    .O_data      (O_data),
    .O_dataValid (O_dataValid),
    .O_sof       (O_sof),
    .O_dataLen   (O_dataLen),
    .O_srcIp     (O_srcIp),
    .O_srcPort   (O_srcPort),
    .O_done      (O_done),
    .O_crcOk     (O_crcOk),
    .O_busy      (O_busy)
  );

  always #10 clk = ~clk;

  int        n_checks = 0;
  int        n_errors = 0;
  bit [7:0]  frm[$];
  bit [7:0]  exp_bytes[$], got_bytes[$];
  int        exp_sof[$], got_sof[$];
  bit [31:0] exp_ip_q[$], got_ip_q[$];
  int        exp_dones = 0, got_dones = 0;
  bit        exp_crc_ok;
  bit [15:0] exp_len, exp_port;
  bit [31:0] exp_ip;
  bit        busy_seen = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (O_sof) begin
      got_sof.push_back(O_dataValid ? got_bytes.size() : -1);
      got_ip_q.push_back(O_srcIp);
    end
    if (O_dataValid) got_bytes.push_back(O_data);
    if (O_done) got_dones++;
    if (O_busy) busy_seen = 1'b1;
  end

  function automatic bit [31:0] frame_crc();
    bit [31:0] c = 32'hFFFFFFFF;
    foreach (frm[i]) begin
      for (int k = 0; k < 8; k++) begin
        if (c[0] ^ frm[i][k]) c = (c >> 1) ^ 32'hEDB88320;
        else                  c = c >> 1;
      end
    end
    return c;
  endfunction

  function automatic frame_t good_frame(input int npay, input int ulen);
    frame_t f;
    f.dmac = MY_MAC;   f.etype = 16'h0800; f.verihl = 8'h45; f.proto = 8'd17;
    f.sip  = $urandom; f.dip   = MY_IP;    f.sport  = 16'($urandom);
    f.dport = MY_PORT; f.ulen  = 16'(ulen); f.npay  = npay; f.flip = -1; f.rnd = 1'b1;
    return f;
  endfunction

  task automatic push16(input bit [15:0] v);
    frm.push_back(v[15:8]);
    frm.push_back(v[7:0]);
  endtask

  task automatic push32(input bit [31:0] v);
    push16(v[31:16]);
    push16(v[15:0]);
  endtask

  // Builds the wire image of a frame and, when asked, records what the receiver must deliver.
  task automatic build(input frame_t f, input bit predict);
    bit [31:0] fcs;
    bit        acc;
    frm.delete();
    for (int i = 0; i < 6; i++) frm.push_back(f.dmac[47 - 8 * i -: 8]);
    for (int i = 0; i < 6; i++) frm.push_back(8'h20 + 8'(i));
    push16(f.etype);
    frm.push_back(f.verihl); frm.push_back(8'h00);
    push16(16'd20 + f.ulen); push16(16'h1234); push16(16'h4000);
    frm.push_back(8'h40); frm.push_back(f.proto);
    push16(16'h0000); push32(f.sip); push32(f.dip);
    push16(f.sport); push16(f.dport); push16(f.ulen); push16(16'h0000);
    for (int i = 0; i < f.npay; i++) frm.push_back(f.rnd ? 8'($urandom) : 8'(i));
    while (frm.size() < 60) frm.push_back(8'h00);
    fcs = ~frame_crc();
    push32({fcs[7:0], fcs[15:8], fcs[23:16], fcs[31:24]});
    if (f.flip >= 0) frm[f.flip] ^= 8'h04;
    if (predict) begin
      acc = (f.dmac == MY_MAC || f.dmac == '1) && f.etype == 16'h0800 && f.verihl == 8'h45 &&
            f.proto == 8'd17 && f.dip == MY_IP && f.dport == MY_PORT && f.ulen >= 16'd8;
      if (acc) begin
        exp_dones++;
        exp_crc_ok = (f.flip < 0);
        if (f.ulen > 16'd8) begin
          exp_sof.push_back(exp_bytes.size());
          exp_ip_q.push_back(f.sip);
          for (int i = 0; i < int'(f.ulen) - 8; i++) exp_bytes.push_back(frm[42 + i]);
          exp_len = f.ulen - 16'd8; exp_ip = f.sip; exp_port = f.sport;
        end
      end
    end
  endtask

  task automatic send_byte(input bit [7:0] b);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); crs = 1'b1; rxd = b[2 * k +: 2];
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk); crs = 1'b0; rxd = 2'b00;
    end
  endtask

  task automatic send(input int gap, input int stop_at);
    for (int i = 0; i < 7; i++) send_byte(8'h55);
    send_byte(8'hD5);
    foreach (frm[i]) if (stop_at < 0 || i < stop_at) send_byte(frm[i]);
    if (stop_at < 0) idle(gap);
  endtask

  task automatic clear_all();
    exp_bytes.delete(); got_bytes.delete(); exp_sof.delete(); got_sof.delete();
    exp_ip_q.delete(); got_ip_q.delete();
    exp_dones = 0; got_dones = 0; busy_seen = 1'b0;
  endtask

  task automatic scenario_check(input string tag);
    check({tag, ".nbytes"}, got_bytes.size(), exp_bytes.size());
    for (int i = 0; i < exp_bytes.size() && i < got_bytes.size(); i++)
      check($sformatf("%s.byte%0d", tag, i), got_bytes[i], exp_bytes[i]);
    check({tag, ".nsof"}, got_sof.size(), exp_sof.size());
    for (int i = 0; i < exp_sof.size() && i < got_sof.size(); i++) begin
      check($sformatf("%s.sofpos%0d", tag, i), got_sof[i], exp_sof[i]);
      check($sformatf("%s.sofip%0d", tag, i), got_ip_q[i], exp_ip_q[i]);
    end
    check({tag, ".ndone"}, got_dones, exp_dones);
    if (exp_dones > 0) check({tag, ".crcok"}, O_crcOk, exp_crc_ok);
    if (exp_sof.size() > 0) begin
      check({tag, ".len"}, O_dataLen, exp_len);
      check({tag, ".srcip"}, O_srcIp, exp_ip);
      check({tag, ".srcport"}, O_srcPort, exp_port);
    end
    check({tag, ".busyseen"}, busy_seen, 1'b1);
    check({tag, ".busyidle"}, O_busy, 1'b0);
    clear_all();
  endtask

  initial begin
    frame_t f, f2;
    int     fault;

    repeat (2) @(negedge clk);
    check("rst.outs_a", {O_dataLen, O_srcIp, O_srcPort}, 64'd0);
    check("rst.outs_b", {O_data, O_dataValid, O_sof, O_done, O_crcOk, O_busy}, 64'd0);
    rst = 1'b0;
    idle(3);

    f = good_frame(22, 30); f.rnd = 1'b0; f.sip = 32'h0A000001; f.sport = 16'd1234;
    build(f, 1'b1); send(8, -1);
    scenario_check("valid30");
    check("valid30.lenfixed", O_dataLen, 16'd22);

    f.flip = 42 + 5;
    build(f, 1'b1); send(8, -1);
    scenario_check("bitflip");

    f = good_frame(10, 18); f.dport = 16'd11452; build(f, 1'b1); send(8, -1);
    scenario_check("badport");
    f = good_frame(10, 18); f.dmac = 48'he86a64fad17c; build(f, 1'b1); send(8, -1);
    scenario_check("badmac");
    f = good_frame(10, 18); f.etype = 16'h0806; build(f, 1'b1); send(8, -1);
    scenario_check("arp");

    f = good_frame(1, 9); build(f, 1'b1); send(8, -1);
    scenario_check("len9pad");

    f  = good_frame(12, 20); f.sip = 32'hC0A80F01; f.sport = 16'd1000;
    f2 = good_frame(7, 15);  f2.sip = 32'hC0A80F02; f2.sport = 16'd2000;
    build(f, 1'b1);  send(2, -1);
    build(f2, 1'b1); send(8, -1);
    scenario_check("b2b");

    f = good_frame(20, 28); build(f, 1'b0); send(0, 42 + 6);
    repeat (2) begin @(negedge clk); crs = 1'b1; rxd = 2'b10; end
    @(negedge clk); rst = 1'b1;
    #1;
    check("abort.outs_a", {O_dataLen, O_srcIp, O_srcPort}, 64'd0);
    check("abort.outs_b", {O_data, O_dataValid, O_sof, O_done, O_crcOk, O_busy}, 64'd0);
    @(negedge clk); rst = 1'b0; crs = 1'b0; rxd = 2'b00;
    idle(4);
    check("abort.nodone", got_dones, 0);
    clear_all();
    f = good_frame(16, 24); build(f, 1'b1); send(8, -1);
    scenario_check("after_abort");

    for (int n = 0; n < 12; n++) begin
      f = good_frame($urandom_range(0, 30), 8);
      f.ulen = 16'(8 + $urandom_range(0, f.npay));
      fault = $urandom_range(0, 11);
      case (fault)
        1: f.dport  = f.dport ^ 16'h0001;
        2: f.dmac   = f.dmac ^ 48'h0100;
        3: f.etype  = 16'h86DD;
        4: f.verihl = 8'h46;
        5: f.proto  = 8'd6;
        6: f.dip    = f.dip ^ 32'h0000_0100;
        7: f.dmac   = '1;
        8: f.ulen   = 16'($urandom_range(0, 7));
        default: ;
      endcase
      if ($urandom_range(0, 3) == 0) f.flip = $urandom_range(42, 42 + f.npay + 3);
      build(f, 1'b1);
      send($urandom_range(2, 6), -1);
    end
    idle(6);
    scenario_check("random");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
